// File: rtl/sys_defs.sv
// Shared definitions for the decode-to-execute issue scoreboard.
package sys_defs;

    localparam int unsigned NUM_REGS_DEF = 32;
    localparam int unsigned REG_ADDR_W   = 5;
    localparam int unsigned CNT_W_DEF    = 2;
    localparam int unsigned STALL_W      = 16;

    // Controller modes: normal issue, quiesce in progress, completion pulse, held quiesced
    typedef enum logic [1:0] {
        SB_RUN   = 2'd0,
        SB_DRAIN = 2'd1,
        SB_DONE  = 2'd2,
        SB_HOLD  = 2'd3
    } sb_state_t;

endpackage : sys_defs

// File: rtl/sb_counter.sv
// Per-register pending-write counter: saturating up/down, simultaneous inc+dec is a no-op.
module sb_counter
    import sys_defs::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             nonzero,
    output logic             nxt_nonzero_c
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // Next count: clamp at both ends so a stray writeback never wraps
    always_comb begin
        cnt_d = cnt_q;
        if (inc && !dec && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (dec && !inc && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt           = cnt_q;
    assign nonzero       = |cnt_q;
    assign nxt_nonzero_c = |cnt_d;

endmodule : sb_counter

// File: rtl/id_scoreboard_ctrl.sv
// In-order issue controller: tracks outstanding register writes, stalls decode
// on RAW/WAW hazards and provides a drain handshake for quiescing the pipeline.
// Optional macro ID_SCOREBOARD_WB_BYPASS_EN lets a same-cycle writeback clear a
// source hazard so the consumer issues in the writeback cycle.
module id_scoreboard_ctrl
    import sys_defs::*;
#(
    parameter int unsigned NUM_REGS = NUM_REGS_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    output logic                  id_ready,
    input  logic                  rs1_r_ena,
    input  logic [REG_ADDR_W-1:0] rs1_r_addr,
    input  logic                  rs2_r_ena,
    input  logic [REG_ADDR_W-1:0] rs2_r_addr,
    input  logic                  rd_w_ena,
    input  logic [REG_ADDR_W-1:0] rd_w_addr,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic                  drain_req,
    output logic                  drain_done,
    output logic                  busy_any,
    output logic [STALL_W-1:0]    stall_cnt
);

    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
    localparam logic [STALL_W-1:0] STALL_MAX = '1;

    logic [CNT_W-1:0]    cnt [NUM_REGS];
    logic [NUM_REGS-1:0] nz;
    logic [NUM_REGS-1:0] nz_nxt;

    logic                issue;
    logic                hazard;
    logic [CNT_W-1:0]    rs1_cnt;
    logic [CNT_W-1:0]    rs2_cnt;
    logic [CNT_W-1:0]    rd_cnt;

    sb_state_t           state_d;
    sb_state_t           state_q;
    logic                drain_done_d;
    logic                drain_done_q;
    logic [STALL_W-1:0]  stall_cnt_d;
    logic [STALL_W-1:0]  stall_cnt_q;

    // x0 is never tracked: its slot reads as permanently idle
    assign cnt[0]    = '0;
    assign nz[0]     = 1'b0;
    assign nz_nxt[0] = 1'b0;

    // One pending-write counter per architectural register x1..x(N-1)
    for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
        sb_counter #(
            .CNT_W         (CNT_W)
        ) u_cnt (
            .clk           (clk),
            .rst_n         (rst_n),
            .inc           (issue && rd_w_ena && (rd_w_addr == REG_ADDR_W'(r))),
            .dec           (wb_valid && (wb_addr == REG_ADDR_W'(r))),
            .cnt           (cnt[r]),
            .nonzero       (nz[r]),
            .nxt_nonzero_c (nz_nxt[r])
        );
    end

    // Effective pending counts seen by the hazard check for this instruction
    always_comb begin
        rs1_cnt = cnt[rs1_r_addr];
        rs2_cnt = cnt[rs2_r_addr];
        rd_cnt  = cnt[rd_w_addr];
`ifdef ID_SCOREBOARD_WB_BYPASS_EN
        // A retiring write is forwarded by the datapath, so discount it here
        if (wb_valid) begin
            if ((wb_addr == rs1_r_addr) && (rs1_cnt != '0)) begin
                rs1_cnt = rs1_cnt - CNT_W'(1);
            end
            if ((wb_addr == rs2_r_addr) && (rs2_cnt != '0)) begin
                rs2_cnt = rs2_cnt - CNT_W'(1);
            end
            if ((wb_addr == rd_w_addr) && (rd_cnt != '0)) begin
                rd_cnt = rd_cnt - CNT_W'(1);
            end
        end
`endif
    end

    // RAW on either source, or the destination counter would overflow
    always_comb begin
        hazard = 1'b0;
        if (rs1_r_ena && (rs1_cnt != '0)) begin
            hazard = 1'b1;
        end
        if (rs2_r_ena && (rs2_cnt != '0)) begin
            hazard = 1'b1;
        end
        if (rd_w_ena && (rd_w_addr != '0) && (rd_cnt == CNT_MAX)) begin
            hazard = 1'b1;
        end
    end

    // Ready is held low while reset is asserted even though the mode reads RUN
    assign id_ready = rst_n && (state_q == SB_RUN) && !hazard;
    assign issue    = id_valid && id_ready;

    // Drain sequencing and stall accounting
    always_comb begin
        state_d      = state_q;
        drain_done_d = 1'b0;
        stall_cnt_d  = stall_cnt_q;

        case (state_q)
            SB_RUN: begin
                if (drain_req) begin
                    state_d = SB_DRAIN;
                end
            end
            SB_DRAIN: begin
                // Look at next-state counts so the last writeback completes the drain
                if (nz_nxt == '0) begin
                    state_d = SB_DONE;
                end
            end
            SB_DONE: begin
                state_d = drain_req ? SB_HOLD : SB_RUN;
            end
            SB_HOLD: begin
                if (!drain_req) begin
                    state_d = SB_RUN;
                end
            end
            default: begin
                state_d = SB_RUN;
            end
        endcase

        drain_done_d = (state_d == SB_DONE);

        if (id_valid && !id_ready && (stall_cnt_q != STALL_MAX)) begin
            stall_cnt_d = stall_cnt_q + STALL_W'(1);
        end
    end

    // Control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= SB_RUN;
            drain_done_q <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            drain_done_q <= drain_done_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign drain_done = drain_done_q;
    assign stall_cnt  = stall_cnt_q;
    assign busy_any   = |nz;

endmodule : id_scoreboard_ctrl

// File: tb/tb_id_scoreboard_ctrl.sv
// Bench for id_scoreboard_ctrl: directed scenarios plus randomized traffic,
// all compared against a count-per-register reference model.
module tb_id_scoreboard_ctrl;

    localparam int MAXC    = 3;
    localparam int M_RUN   = 0;
    localparam int M_DRAIN = 1;
    localparam int M_DONE  = 2;
    localparam int M_HOLD  = 3;
`ifdef ID_SCOREBOARD_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct {
        logic       v;
        logic       r1e;
        logic [4:0] r1;
        logic       r2e;
        logic [4:0] r2;
        logic       rde;
        logic [4:0] rd;
        logic       wbv;
        logic [4:0] wba;
        logic       dr;
    } stim_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic        id_ready;
    logic        rs1_r_ena;
    logic [4:0]  rs1_r_addr;
    logic        rs2_r_ena;
    logic [4:0]  rs2_r_addr;
    logic        rd_w_ena;
    logic [4:0]  rd_w_addr;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic        drain_req;
    logic        drain_done;
    logic        busy_any;
    logic [15:0] stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    int m_cnt [32];
    int m_mode;
    int m_stall;

    always #5 clk = ~clk;

    id_scoreboard_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .rs1_r_ena  (rs1_r_ena),
        .rs1_r_addr (rs1_r_addr),
        .rs2_r_ena  (rs2_r_ena),
        .rs2_r_addr (rs2_r_addr),
        .rd_w_ena   (rd_w_ena),
        .rd_w_addr  (rd_w_addr),
        .wb_valid   (wb_valid),
        .wb_addr    (wb_addr),
        .drain_req  (drain_req),
        .drain_done (drain_done),
        .busy_any   (busy_any),
        .stall_cnt  (stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic stim_t mk(input int v, input int r1e, input int r1, input int r2e,
                                 input int r2, input int rde, input int rd, input int wbv,
                                 input int wba, input int dr);
        stim_t s;
        s.v   = (v != 0);
        s.r1e = (r1e != 0);
        s.r1  = 5'(r1);
        s.r2e = (r2e != 0);
        s.r2  = 5'(r2);
        s.rde = (rde != 0);
        s.rd  = 5'(rd);
        s.wbv = (wbv != 0);
        s.wba = 5'(wba);
        s.dr  = (dr != 0);
        return s;
    endfunction

    // Outstanding writes to a register as seen by an instruction in this cycle
    function automatic int eff(input logic [4:0] a, input stim_t s);
        int c;
        c = m_cnt[a];
        if (BYPASS && s.wbv && (s.wba == a) && (c > 0)) c--;
        return c;
    endfunction

    function automatic bit model_busy();
        for (int i = 0; i < 32; i++) if (m_cnt[i] != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        m_mode  = M_RUN;
        m_stall = 0;
    endtask

    task automatic drive_idle();
        id_valid  = 1'b0; rs1_r_ena = 1'b0; rs1_r_addr = '0; rs2_r_ena = 1'b0; rs2_r_addr = '0;
        rd_w_ena  = 1'b0; rd_w_addr = '0;   wb_valid   = 1'b0; wb_addr  = '0; drain_req = 1'b0;
    endtask

    // One clock: drive, check outputs against the model, then advance the model
    task automatic cycle(input stim_t s, output logic rdy);
        bit haz;
        bit exp_rdy;
        bit issue;
        @(negedge clk);
        id_valid   = s.v;   rs1_r_ena = s.r1e; rs1_r_addr = s.r1;
        rs2_r_ena  = s.r2e; rs2_r_addr = s.r2; rd_w_ena   = s.rde;
        rd_w_addr  = s.rd;  wb_valid  = s.wbv; wb_addr    = s.wba;
        drain_req  = s.dr;
        #1;
        haz = (s.r1e && eff(s.r1, s) != 0) || (s.r2e && eff(s.r2, s) != 0) ||
              (s.rde && s.rd != 0 && eff(s.rd, s) == MAXC);
        exp_rdy = (m_mode == M_RUN) && !haz;
        chk("id_ready",   32'(id_ready),   32'(exp_rdy));
        chk("busy_any",   32'(busy_any),   32'(model_busy()));
        chk("drain_done", 32'(drain_done), 32'(m_mode == M_DONE));
        chk("stall_cnt",  32'(stall_cnt),  32'(m_stall));
        rdy = id_ready;

        issue = s.v && exp_rdy;
        if (issue && s.rde && s.rd != 0) m_cnt[s.rd]++;
        if (s.wbv && s.wba != 0 && m_cnt[s.wba] > 0) m_cnt[s.wba]--;
        if (s.v && !exp_rdy && m_stall < 65535) m_stall++;
        case (m_mode)
            M_RUN:   if (s.dr) m_mode = M_DRAIN;
            M_DRAIN: if (!model_busy()) m_mode = M_DONE;
            M_DONE:  m_mode = s.dr ? M_HOLD : M_RUN;
            default: if (!s.dr) m_mode = M_RUN;
        endcase
    endtask

    // Retire every outstanding write so the next scenario starts clean
    task automatic flush_all();
        logic r;
        for (int i = 1; i < 32; i++) begin
            while (m_cnt[i] > 0) cycle(mk(0, 0, 0, 0, 0, 0, 0, 1, i, 0), r);
        end
    endtask

    initial begin
        logic r;
        stim_t s;
        bit dr_lvl;
        int wa;

        model_reset();
        drive_idle();
        rst_n = 1'b0;
        #12;
        chk("rst_id_ready",   32'(id_ready),   32'd0);
        chk("rst_drain_done", 32'(drain_done), 32'd0);
        chk("rst_busy_any",   32'(busy_any),   32'd0);
        chk("rst_stall_cnt",  32'(stall_cnt),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // RAW: producer x5, dependent stalls until writeback
        cycle(mk(1, 0, 0, 0, 0, 1, 5, 0, 0, 0), r); chk("raw_producer", 32'(r), 32'd1);
        cycle(mk(1, 1, 5, 0, 0, 0, 0, 0, 0, 0), r); chk("raw_stall",    32'(r), 32'd0);
        cycle(mk(1, 1, 5, 0, 0, 0, 0, 0, 0, 0), r); chk("raw_stall2",   32'(r), 32'd0);
        cycle(mk(1, 1, 5, 0, 0, 0, 0, 1, 5, 0), r); chk("raw_wb_cycle", 32'(r), 32'(BYPASS));
        cycle(mk(1, 1, 5, 0, 0, 0, 0, 0, 0, 0), r); chk("raw_after_wb", 32'(r), 32'd1);

        // WAW saturation on x7
        for (int i = 0; i < 3; i++) begin
            cycle(mk(1, 0, 0, 0, 0, 1, 7, 0, 0, 0), r); chk("waw_fill", 32'(r), 32'd1);
        end
        cycle(mk(1, 0, 0, 0, 0, 1, 7, 0, 0, 0), r); chk("waw_sat",      32'(r), 32'd0);
        cycle(mk(1, 0, 0, 0, 0, 1, 7, 1, 7, 0), r); chk("waw_wb_cycle", 32'(r), 32'(BYPASS));
        cycle(mk(1, 0, 0, 0, 0, 1, 7, 0, 0, 0), r); chk("waw_after_wb", 32'(r), 32'(!BYPASS));
        flush_all();

        // Same-cycle issue and writeback of x9 leaves one write pending
        cycle(mk(1, 0, 0, 0, 0, 1, 9, 0, 0, 0), r); chk("same_first", 32'(r), 32'd1);
        cycle(mk(1, 0, 0, 0, 0, 1, 9, 1, 9, 0), r); chk("same_both",  32'(r), 32'd1);
        cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), r); chk("same_busy",  32'(busy_any), 32'd1);
        cycle(mk(1, 1, 9, 0, 0, 0, 0, 0, 0, 0), r); chk("same_pend",  32'(r), 32'd0);
        cycle(mk(0, 0, 0, 0, 0, 0, 0, 1, 9, 0), r);
        cycle(mk(1, 1, 9, 0, 0, 0, 0, 0, 0, 0), r); chk("same_clear", 32'(r), 32'd1);

        // x0 is never tracked
        for (int i = 0; i < 5; i++) begin
            cycle(mk(1, 1, 0, 1, 0, 1, 0, 1, 0, 0), r);
            chk("x0_ready", 32'(r), 32'd1);
            chk("x0_busy",  32'(busy_any), 32'd0);
        end

        // Drain with two writes pending on x3
        cycle(mk(1, 0, 0, 0, 0, 1, 3, 0, 0, 0), r);
        cycle(mk(1, 0, 0, 0, 0, 1, 3, 0, 0, 0), r);
        cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), r);
        cycle(mk(1, 1, 4, 0, 0, 0, 0, 1, 3, 1), r); chk("drain_blocks", 32'(r), 32'd0);
        cycle(mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 1), r); chk("drain_pending", 32'(drain_done), 32'd0);
        cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), r); chk("drain_pulse", 32'(drain_done), 32'd1);
        cycle(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1), r); chk("drain_one_shot", 32'(drain_done), 32'd0);
        chk("hold_blocks", 32'(r), 32'd0);
        cycle(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), r); chk("hold_exit_cycle", 32'(r), 32'd0);
        cycle(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), r); chk("run_again", 32'(r), 32'd1);

        // Drain with nothing outstanding: pulse two cycles after the request
        cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), r); chk("idle_drain_c0", 32'(drain_done), 32'd0);
        cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), r); chk("idle_drain_c1", 32'(drain_done), 32'd0);
        cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), r); chk("idle_drain_c2", 32'(drain_done), 32'd1);

        // Reset in the middle of a drain with x4 outstanding
        cycle(mk(1, 0, 0, 0, 0, 1, 4, 0, 0, 0), r);
        cycle(mk(1, 1, 4, 0, 0, 0, 0, 0, 0, 1), r);
        cycle(mk(1, 1, 4, 0, 0, 0, 0, 0, 0, 1), r);
        @(negedge clk);
        drive_idle();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_id_ready",   32'(id_ready),   32'd0);
        chk("mid_rst_drain_done", 32'(drain_done), 32'd0);
        chk("mid_rst_busy_any",   32'(busy_any),   32'd0);
        chk("mid_rst_stall_cnt",  32'(stall_cnt),  32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(mk(1, 1, 4, 0, 0, 0, 0, 0, 0, 0), r); chk("post_rst_ready", 32'(r), 32'd1);
        cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), r); chk("post_rst_no_pulse", 32'(drain_done), 32'd0);

        // Randomized traffic on a small register window to provoke hazards
        dr_lvl = 1'b0;
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 24) == 0) dr_lvl = !dr_lvl;
            wa = int'($urandom_range(0, 7));
            s = mk(($urandom_range(0, 3) != 0) ? 1 : 0,
                   int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                   ($urandom_range(0, 3) != 0) ? 1 : 0, int'($urandom_range(0, 7)),
                   (m_cnt[wa] > 0) ? int'($urandom_range(0, 1)) : ((wa == 0) ? 1 : 0),
                   wa, dr_lvl ? 1 : 0);
            cycle(s, r);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_id_scoreboard_ctrl

// File: doc/id_scoreboard_ctrl.md
Name: id_scoreboard_ctrl

Overview:
- In-order issue controller between the decode stage and execute.
- Tracks outstanding register-file writes per architectural register and stalls decode on RAW/WAW hazards.
- Releases entries on writeback.
- Provides a drain sequence so the pipeline can be quiesced before a sys/CSR instruction or a flush.

Parameters:
- NUM_REGS, 32, architectural integer registers; x0 is never tracked.
- CNT_W, 2, width of the per-register pending-write counter; max in-flight writes per register = 2^CNT_W-1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  decode holds a valid instruction
- id_ready  out  1  controller accepts the instruction this cycle (issue)
- rs1_r_ena  in  1  instruction reads rs1
- rs1_r_addr  in  5  rs1 index
- rs2_r_ena  in  1  instruction reads rs2
- rs2_r_addr  in  5  rs2 index
- rd_w_ena  in  1  instruction writes rd
- rd_w_addr  in  5  rd index
- wb_valid  in  1  a register write retires this cycle
- wb_addr  in  5  retiring rd index
- drain_req  in  1  level; request a pipeline quiesce
- drain_done  out  1  one-cycle pulse when drain completes
- busy_any  out  1  any counter non-zero
- stall_cnt  out  16  saturating count of stalled-valid cycles

Behaviour:
- Reset (async, rst_n=0):
  - all counters 0; FSM=RUN; stall_cnt=0.
  - Outputs: id_ready=0, drain_done=0, busy_any=0.
- Per-register state: cnt[r] of CNT_W bits. cnt[0] is hard-wired 0; issue/wb to x0 is ignored.
- Hazard conditions, combinational on registered cnt:
  - raw1 = rs1_r_ena & cnt[rs1]!=0
  - raw2 = rs2_r_ena & cnt[rs2]!=0
  - sat = rd_w_ena & rd!=0 & cnt[rd]==max
  - hazard = raw1|raw2|sat
- id_ready = (state==RUN) & ~hazard. id_ready is combinational and may depend on id_valid-independent inputs only. issue = id_valid & id_ready.
- Counter update per cycle:
  - cnt[rd] += issue & rd_w_ena & rd!=0
  - cnt[wb_addr] -= wb_valid & wb_addr!=0
  - Same register in both: net unchanged.
- wb_valid on a zero counter: counter stays 0 (no underflow). Optional SVA assertion flags it as an error.
- stall_cnt increments when id_valid & ~id_ready; saturates at 0xFFFF.
- busy_any = OR of all cnt!=0 (registered state).
- FSM:
  - RUN: drain_req=1 -> DRAIN. While in RUN, normal issue.
  - DRAIN: id_ready=0; writebacks still processed. When all counters reach 0 (evaluated on next-state values) -> DONE.
  - DONE: drain_done=1 for exactly one cycle. Then -> HOLD if drain_req still 1, else RUN.
  - HOLD: id_ready=0. drain_req=0 -> RUN.
- Latency: issue-to-counter visible 1 cycle. A dependent instruction presented the cycle after its producer issues is stalled.
- drain_req asserted while counters already 0: RUN -> DRAIN -> DONE. drain_done is 2 cycles after drain_req rises.
- Reset mid-drain: immediate return to RUN with cleared counters; no drain_done pulse.

Optional Feature:
- Macro: ID_SCOREBOARD_WB_BYPASS_EN.
- Defined: hazard terms use cnt minus same-cycle writeback. If wb_valid & wb_addr==rs and cnt[rs]==1, that source is not a hazard, so issue can occur in the writeback cycle. Datapath forwards wb data.
- Undefined: hazards use registered cnt only; the consumer issues one cycle after writeback.

Decomposition:
- Shared package sys_defs: NUM_REGS, REG_ADDR_W=5, CNT_W default, and sb_state_t enum {SB_RUN, SB_DRAIN, SB_DONE, SB_HOLD}.
- Sub-module sb_counter: one per-register up/down saturating counter with inc/dec inputs, cnt and nonzero outputs, async active-low reset. Instantiate it for r=1..NUM_REGS-1 via generate.

Test Plan:
- RAW stall: issue addi x5 (rd=5); next cycle present rs1=5 -> id_ready=0 until wb_valid wb_addr=5. Without bypass, issue is 1 cycle after wb. With ID_SCOREBOARD_WB_BYPASS_EN, issue is the same cycle.
- WAW saturation (CNT_W=2): issue 3 writes to x7 with no wb -> 4th write to x7 stalled, cnt[7]=3. One wb_addr=7 -> 4th issues next cycle.
- Simultaneous issue rd=9 and wb_addr=9 with cnt[9]=1 -> cnt[9] stays 1, busy_any=1.
- x0 handling: issue rd=0 and rs1=0 repeatedly -> never stalls, busy_any=0. wb_addr=0 -> no change.
- Drain: cnt[3]=2, assert drain_req -> id_ready=0. Two wb_addr=3 cycles -> DONE, drain_done pulses one cycle. Drop drain_req in HOLD -> RUN and id_ready=1.
- Async reset: assert rst_n=0 mid-DRAIN with cnt[4]=1 -> all outputs 0 immediately. After release: RUN, cnt all 0, stall_cnt=0.
